// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder slice and a carry flop, LSB first.
// Optional subtract mode (port sub, borrow on cout) when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             sub_in;
  logic             sub_q;
  logic             s_bit;
  logic             maj;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_d;
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
  assign sub_q  = 1'b0;
`endif

  assign s_bit = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign maj   = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

  // Sum bits are shifted into the top of a_sh as operand bits leave the bottom,
  // so a_sh doubles as the result accumulator.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
    sub_d   = sub_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b ^ {WIDTH{sub_in}};
          carry_d = sub_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef SERIAL_ADDER_SUB_EN
          sub_d   = sub_in;
`endif
        end
      end
      SHIFT: begin
        a_sh_d  = {s_bit, a_sh_q[WIDTH-1:1]};
        b_sh_d  = b_sh_q >> 1;
        carry_d = maj;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {s_bit, a_sh_q[WIDTH-1:1]};
          cout_d  = maj ^ sub_q;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8); subtract vectors run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks;
  int failures;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one operation and watch 12 edges; optionally pulse start again at
  // edge offset restart_at with different operands (must be ignored).
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic [W-1:0] prev_sum, input logic prev_cout,
                        input int restart_at, input logic [W-1:0] ra, input logic [W-1:0] rb,
                        output int lat, output int busy_cyc, output int done_cnt,
                        output int hold_err);
    a = oa; b = ob; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1; done_cnt = 0; hold_err = 0;
    busy_cyc = busy ? 1 : 0;
    for (int i = 1; i <= 12; i++) begin
      if (i == restart_at) begin
        a = ra; b = rb; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = i;
      end
      if (lat < 0 && (sum !== prev_sum || cout !== prev_cout)) hold_err++;
    end
    start = 1'b0;
  endtask

  int lat, bc, dc, he;
  int ndone, first_done, last_done, bad_gap, bad_sum;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    tick(); tick();
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_sum",  {24'b0, sum},  32'h0);
    check("rst_cout", {31'b0, cout}, 32'h0);
    rst_n = 1'b1;
    tick();

    // 0x3C + 0x0F
    run_op(8'h3C, 8'h0F, 8'h00, 1'b0, 0, 8'h00, 8'h00, lat, bc, dc, he);
    check("op1_latency", lat, 8);
    check("op1_busy_cycles", bc, 9);
    check("op1_done_count", dc, 1);
    check("op1_sum", {24'b0, sum}, 32'h4B);
    check("op1_cout", {31'b0, cout}, 32'h0);
    check("op1_hold", he, 0);

    // 0xFF + 0x01 wraps with carry
    run_op(8'hFF, 8'h01, 8'h4B, 1'b0, 0, 8'h00, 8'h00, lat, bc, dc, he);
    check("op2_sum", {24'b0, sum}, 32'h00);
    check("op2_cout", {31'b0, cout}, 32'h1);
    check("op2_hold", he, 0);
    check("op2_latency", lat, 8);

    // 0x80 + 0x80
    run_op(8'h80, 8'h80, 8'h00, 1'b1, 0, 8'h00, 8'h00, lat, bc, dc, he);
    check("op3_sum", {24'b0, sum}, 32'h00);
    check("op3_cout", {31'b0, cout}, 32'h1);
    check("op3_done_count", dc, 1);

    // second start mid-operation with new operands must be ignored
    run_op(8'h55, 8'h0A, 8'h00, 1'b1, 3, 8'h11, 8'h22, lat, bc, dc, he);
    check("ign_sum", {24'b0, sum}, 32'h5F);
    check("ign_cout", {31'b0, cout}, 32'h0);
    check("ign_done_count", dc, 1);
    check("ign_latency", lat, 8);
    check("ign_hold", he, 0);

    // asynchronous reset in the middle of SHIFT
    a = 8'h3C; b = 8'h0F; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    check("abort_sum",  {24'b0, sum},  32'h0);
    check("abort_cout", {31'b0, cout}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    dc = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dc++;
    end
    check("abort_no_done", dc, 0);
    run_op(8'h12, 8'h34, 8'h00, 1'b0, 0, 8'h00, 8'h00, lat, bc, dc, he);
    check("post_abort_sum", {24'b0, sum}, 32'h46);
    check("post_abort_cout", {31'b0, cout}, 32'h0);
    check("post_abort_done", dc, 1);

    // start held high: one operation per W+2 cycles
    a = 8'h01; b = 8'h02; start = 1'b1;
    ndone = 0; first_done = -1; last_done = -1; bad_gap = 0; bad_sum = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = i;
        else if (i - last_done != 10) bad_gap++;
        last_done = i;
        if (sum !== 8'h03 || cout !== 1'b0) bad_sum++;
      end
    end
    start = 1'b0;
    check("cont_done_count", ndone, 4);
    check("cont_first_done", first_done, 9);
    check("cont_bad_gap", bad_gap, 0);
    check("cont_bad_sum", bad_sum, 0);
    tick(); tick(); tick(); tick();

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run_op(8'h05, 8'h07, 8'h03, 1'b0, 0, 8'h00, 8'h00, lat, bc, dc, he);
    check("sub1_sum", {24'b0, sum}, 32'hFE);
    check("sub1_borrow", {31'b0, cout}, 32'h1);
    run_op(8'h07, 8'h05, 8'hFE, 1'b1, 0, 8'h00, 8'h00, lat, bc, dc, he);
    check("sub2_sum", {24'b0, sum}, 32'h02);
    check("sub2_borrow", {31'b0, cout}, 32'h0);
    sub = 1'b0;
    run_op(8'hFF, 8'h01, 8'h02, 1'b0, 0, 8'h00, 8'h00, lat, bc, dc, he);
    check("sub0_sum", {24'b0, sum}, 32'h00);
    check("sub0_cout", {31'b0, cout}, 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
